// File: rtl/systolic_tile_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : systolic_tile_sequencer_if
// Purpose : Bundle of operand-memory, result-memory, systolic-array and
//           control signals shared by the tile sequencer and its environment.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_tile_sequencer_if;
  logic        start;
  logic        busy;
  logic        done_all;
  logic [7:0]  a_addr0, a_addr1, a_addr2, a_addr3;
  logic [31:0] a_data0, a_data1, a_data2, a_data3;
  logic [7:0]  b_addr0, b_addr1, b_addr2, b_addr3;
  logic [31:0] b_data0, b_data1, b_data2, b_data3;
  logic [31:0] inp_west0, inp_west1, inp_west2, inp_west3;
  logic [31:0] inp_north0, inp_north1, inp_north2, inp_north3;
  logic        arr_rst;
  logic        arr_done;
  logic [63:0] result0, result1, result2, result3;
  logic [63:0] result4, result5, result6, result7;
  logic [63:0] result8, result9, result10, result11;
  logic [63:0] result12, result13, result14, result15;
  logic        c_we;
  logic [7:0]  c_addr;
  logic [63:0] c_data;

  // Sequencer side
  modport master (
    input  start, arr_done,
    input  a_data0, a_data1, a_data2, a_data3,
    input  b_data0, b_data1, b_data2, b_data3,
    input  result0, result1, result2, result3, result4, result5, result6, result7,
    input  result8, result9, result10, result11, result12, result13, result14, result15,
    output busy, done_all, arr_rst, c_we, c_addr, c_data,
    output a_addr0, a_addr1, a_addr2, a_addr3,
    output b_addr0, b_addr1, b_addr2, b_addr3,
    output inp_west0, inp_west1, inp_west2, inp_west3,
    output inp_north0, inp_north1, inp_north2, inp_north3
  );

  // Memory / array / host side
  modport slave (
    output start, arr_done,
    output a_data0, a_data1, a_data2, a_data3,
    output b_data0, b_data1, b_data2, b_data3,
    output result0, result1, result2, result3, result4, result5, result6, result7,
    output result8, result9, result10, result11, result12, result13, result14, result15,
    input  busy, done_all, arr_rst, c_we, c_addr, c_data,
    input  a_addr0, a_addr1, a_addr2, a_addr3,
    input  b_addr0, b_addr1, b_addr2, b_addr3,
    input  inp_west0, inp_west1, inp_west2, inp_west3,
    input  inp_north0, inp_north1, inp_north2, inp_north3
  );
endinterface

`default_nettype wire

// File: rtl/systolic_tile_sequencer.sv
//------------------------------------------------------------------------------
// Module  : systolic_tile_sequencer
// Purpose : Runs a 16x16 x 16x16 matrix multiply on a 4x4 systolic array:
//           walks output tiles and K-tiles, feeds skewed operand lanes,
//           accumulates per-PE results and streams finished C tiles out.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_tile_sequencer #(
  parameter int N   = 4,
  parameter int DIM = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  systolic_tile_sequencer_if.master   bus
);

  localparam int TILES = DIM / N;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_ACC   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      r_state;
  logic [3:0]  r_tile;      // {ti, tj}
  logic [1:0]  r_tk;
  logic [3:0]  r_u;         // feed step
  logic [3:0]  r_widx;      // element index within tile during WRITE
  logic [63:0] r_acc [16];
  logic [N-1:0] r_lane_v;   // lane validity of the address issued last cycle
  logic        r_busy;
  logic        r_done_all;
  logic        r_arr_rst;
  logic        r_c_we;
  logic [7:0]  r_c_addr;
  logic [63:0] r_c_data;

  logic [31:0] w_a_data [N];
  logic [31:0] w_b_data [N];
  logic [7:0]  w_a_addr [N];
  logic [7:0]  w_b_addr [N];
  logic [31:0] w_west   [N];
  logic [31:0] w_north  [N];
  logic [N-1:0] w_lane_v;
  logic [63:0] w_result [16];
  logic [63:0] w_acc_sum [16];
  logic [3:0]  w_nidx;

  assign w_a_data[0] = bus.a_data0;
  assign w_a_data[1] = bus.a_data1;
  assign w_a_data[2] = bus.a_data2;
  assign w_a_data[3] = bus.a_data3;
  assign w_b_data[0] = bus.b_data0;
  assign w_b_data[1] = bus.b_data1;
  assign w_b_data[2] = bus.b_data2;
  assign w_b_data[3] = bus.b_data3;

  assign w_result[0]  = bus.result0;
  assign w_result[1]  = bus.result1;
  assign w_result[2]  = bus.result2;
  assign w_result[3]  = bus.result3;
  assign w_result[4]  = bus.result4;
  assign w_result[5]  = bus.result5;
  assign w_result[6]  = bus.result6;
  assign w_result[7]  = bus.result7;
  assign w_result[8]  = bus.result8;
  assign w_result[9]  = bus.result9;
  assign w_result[10] = bus.result10;
  assign w_result[11] = bus.result11;
  assign w_result[12] = bus.result12;
  assign w_result[13] = bus.result13;
  assign w_result[14] = bus.result14;
  assign w_result[15] = bus.result15;

  // Skewed lane addressing: lane g handles k = u - g. West and north lanes
  // share the same validity window, so one valid bit per lane index serves both.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [3:0] w_k;
    assign w_k         = r_u - 4'(g);
    assign w_lane_v[g] = (r_state == S_FEED) && (r_u <= 4'd10) &&
                         (r_u >= 4'(g)) && (w_k < 4'd4);
    assign w_a_addr[g] = {r_tile[3:2], 2'(g), r_tk, w_k[1:0]};
    assign w_b_addr[g] = {r_tk, w_k[1:0], r_tile[1:0], 2'(g)};
    assign w_west[g]   = r_lane_v[g] ? w_a_data[g] : 32'd0;
    assign w_north[g]  = r_lane_v[g] ? w_b_data[g] : 32'd0;
  end

  // First K-tile of a tile overwrites; later ones add (mod 2^64)
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_acc_sum[i] = ((r_tk == 2'd0) ? 64'd0 : r_acc[i]) + w_result[i];
    end
  end

  assign w_nidx = r_widx + 4'd1;

  // Sequencer FSM with registered control and result-memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tile     <= 4'd0;
      r_tk       <= 2'd0;
      r_u        <= 4'd0;
      r_widx     <= 4'd0;
      r_lane_v   <= '0;
      r_busy     <= 1'b0;
      r_done_all <= 1'b0;
      r_arr_rst  <= 1'b0;
      r_c_we     <= 1'b0;
      r_c_addr   <= 8'd0;
      r_c_data   <= 64'd0;
      for (int i = 0; i < 16; i++) r_acc[i] <= 64'd0;
    end else begin
      r_done_all <= 1'b0;
      r_arr_rst  <= 1'b0;
      r_c_we     <= 1'b0;
      r_lane_v   <= w_lane_v;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_tile    <= 4'd0;
            r_tk      <= 2'd0;
            for (int i = 0; i < 16; i++) r_acc[i] <= 64'd0;
            r_busy    <= 1'b1;
            r_arr_rst <= 1'b1;
            r_state   <= S_CLR;
          end
        end
        S_CLR: begin
          r_u     <= 4'd0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_u == 4'd11) r_state <= S_WAIT;
          else              r_u     <= r_u + 4'd1;
        end
        S_WAIT: begin
          if (bus.arr_done) r_state <= S_ACC;
        end
        S_ACC: begin
          for (int i = 0; i < 16; i++) r_acc[i] <= w_acc_sum[i];
          if (r_tk == 2'(TILES - 1)) begin
            r_widx   <= 4'd0;
            r_c_we   <= 1'b1;
            r_c_addr <= {r_tile[3:2], 2'd0, r_tile[1:0], 2'd0};
            r_c_data <= w_acc_sum[0];
            r_state  <= S_WRITE;
          end else begin
            r_tk      <= r_tk + 2'd1;
            r_arr_rst <= 1'b1;
            r_state   <= S_CLR;
          end
        end
        S_WRITE: begin
          if (r_widx == 4'd15) begin
            r_c_addr <= 8'd0;
            r_c_data <= 64'd0;
            r_tk     <= 2'd0;
            if (r_tile == 4'(TILES * TILES - 1)) begin
              r_done_all <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_tile    <= r_tile + 4'd1;
              for (int i = 0; i < 16; i++) r_acc[i] <= 64'd0;
              r_arr_rst <= 1'b1;
              r_state   <= S_CLR;
            end
          end else begin
            r_widx   <= w_nidx;
            r_c_we   <= 1'b1;
            r_c_addr <= {r_tile[3:2], w_nidx[3:2], r_tile[1:0], w_nidx[1:0]};
            r_c_data <= r_acc[w_nidx];
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done_all   = r_done_all;
  assign bus.arr_rst    = r_arr_rst;
  assign bus.c_we       = r_c_we;
  assign bus.c_addr     = r_c_addr;
  assign bus.c_data     = r_c_data;
  assign bus.a_addr0    = w_a_addr[0];
  assign bus.a_addr1    = w_a_addr[1];
  assign bus.a_addr2    = w_a_addr[2];
  assign bus.a_addr3    = w_a_addr[3];
  assign bus.b_addr0    = w_b_addr[0];
  assign bus.b_addr1    = w_b_addr[1];
  assign bus.b_addr2    = w_b_addr[2];
  assign bus.b_addr3    = w_b_addr[3];
  assign bus.inp_west0  = w_west[0];
  assign bus.inp_west1  = w_west[1];
  assign bus.inp_west2  = w_west[2];
  assign bus.inp_west3  = w_west[3];
  assign bus.inp_north0 = w_north[0];
  assign bus.inp_north1 = w_north[1];
  assign bus.inp_north2 = w_north[2];
  assign bus.inp_north3 = w_north[3];

endmodule

`default_nettype wire

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Controller that runs a complete 16x16 by 16x16 matrix multiply on the 4x4 systolic array.
- Walks the output tiles and, for each one, the four K-tiles.
- Reads A and B from external single-cycle-latency memories and drives the skewed west/north operand lanes.
- Clears the array between K-tiles and accumulates the array's per-PE results into 16 local 64-bit accumulators.
- Streams each finished C tile to a result memory.
- Sits between the operand/result memories and the systolic array.

## Interface
Parameters (fixed; listed for documentation, not to be overridden):
- N, 4, array edge (PEs per row/column)
- DIM, 16, matrix edge; DIM/N = 4 tiles per dimension

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a full multiply; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done_all
- done_all  out  1  one-cycle pulse after the last C write
- a_addr0..3  out  8 each  A address, row*16+col, one per west lane
- a_data0..3  in  32 each  A read data, valid the cycle after its address
- b_addr0..3  out  8 each  B address, row*16+col, one per north lane
- b_data0..3  in  32 each  B read data, valid the cycle after its address
- inp_west0..3  out  32 each  array west inputs (rows 0..3)
- inp_north0..3  out  32 each  array north inputs (cols 0..3)
- arr_rst  out  1  array clear pulse
- arr_done  in  1  array computation complete
- result0..15  in  64 each  PE results, row-major (result[4r+c])
- c_we  out  1  C write enable
- c_addr  out  8  C address, row*16+col
- c_data  out  64  C write data

## Operation
- Loop order:
  - output tile ti (0..3) outer, tj (0..3) inner
  - K-tile tk (0..3) innermost
- States:
  - IDLE: start=1 -> CLR; tile counters and accumulators cleared.
  - CLR: arr_rst=1 for exactly 1 cycle -> FEED, step u=0.
  - FEED: 12 cycles (u=0..11). Addresses are issued for u=0..10; lanes are driven from data in cycles u=1..11.
  - WAIT: stay until arr_done=1; exit on the first such cycle -> ACC.
  - ACC: 1 cycle, acc[i] += result[i] for all 16, mod 2^64. Then tk<3 -> tk+1, CLR; tk=3 -> WRITE.
  - WRITE: 16 cycles, one C element per cycle, row-major within the tile. Then next tile -> CLR (accumulators zeroed); last tile -> DONE.
  - DONE: done_all=1 for 1 cycle -> IDLE.
- Skew at address step u:
  - West lane r is valid when 0<=u-r<4; address A[4ti+r][4tk+u-r].
  - North lane c is valid when 0<=u-c<4; address B[4tk+u-c][4tj+c].
- Lane validity is registered alongside the address. In the following cycle, inp_* = read data if valid, else 0.
- Outside FEED, all inp_* = 0.
- c_addr = (4ti+r)*16 + 4tj+c; c_data = acc[4r+c].
- The first ACC of each tile overwrites rather than adds, equivalent to accumulating onto zero.
- start while busy is ignored. start in DONE is ignored.
- Addresses are don't-care outside FEED; the bench checks them only when the registered lane is valid.

## Timing
- Reset values: busy=0, done_all=0, arr_rst=0, c_we=0, c_addr=0, c_data=0, all inp_*=0, all accumulators 0; state IDLE.
- Start handshake: start seen in IDLE in cycle T. Then busy=1 from T+1, and arr_rst=1 in T+1.
- K-tile cost: 1 (CLR) + 12 (FEED) + W (WAIT, >=1) + 1 (ACC) cycles.
- Write cost per tile: 16 cycles, c_we continuously high.
- Total with arr_done ready on WAIT entry (W=1): 16 tiles × (4×15 + 16) = 1216 cycles from CLR entry to DONE.
- done_all and busy fall: in the DONE cycle busy is still 1; both are 0 the next cycle.
- Reset mid-operation: on assertion, state IDLE and all outputs at reset values immediately. No partial C writes follow. A new start after reset produces a fully correct result.
- arr_done held high during CLR/FEED is ignored; it is only sampled in WAIT.

## Test plan
- A=identity, B[i][j]=i*16+j -> C[i][j]=i*16+j. Check C[0][0]=0, C[15][15]=255, 256 c_we pulses, done_all once.
- A and B all 1 -> every C=16. Total cycles 1216 with a zero-latency array model.
- A[i][j]=i+j, B[i][j]=(i>=j)?i-j:0 -> C[0][0]=1240 and C[15][15]=0. Full matrix compared against a reference model.
- A=B=all 0xFFFFFFFF -> every C=0xFFFFFFE000000010 (64-bit wrap).
- Assert rst during FEED of tile (1,2) -> outputs zero, busy=0 same cycle. Re-start with the identity case -> correct C.
- Pulse start at busy cycle 50, and hold arr_done low for 20 cycles in one WAIT -> no restart, WAIT extends by exactly 20 cycles, results unchanged.
